// File: rtl/serializer_pkg.sv
// Shared state encoding and width helper for the bit serializer.
package serializer_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_PAR   = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        PAR   = ST_PAR
    } state_t;

    // ceil(log2(v)), never below 1 so counters always have at least one bit
    function automatic int CLOG2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++)
            if ((longint'(1) << i) < longint'(v))
                r = i + 1;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Bit-period prescaler: tick is a registered strobe that is high during the
// last clk of every DIV-cycle period while counting is enabled.
module tick_prescaler
    import serializer_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int W = CLOG2(DIV);
    localparam logic [W-1:0] TOP = W'(DIV - 1);

    logic [W-1:0] cnt;
    logic [W-1:0] cnt_n;

    always_comb begin
        cnt_n = (cnt == TOP) ? '0 : cnt + W'(1);
    end

    // tick is computed from the count value of the coming cycle so it lines up
    // with that cycle without a combinational output path
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            tick <= (TOP == '0);
        end else if (en) begin
            cnt  <= cnt_n;
            tick <= (cnt_n == TOP);
        end else begin
            cnt  <= '0;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-load serializer: shifts a word out on x, one bit per DIV clks.
// Define SERIALIZER_PARITY_EN to append an even-parity bit after the data.
module bit_serializer
    import serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DIV       = 50_000_000,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic             ready,
    output logic             x,
    output logic             step,
    output logic             busy
);

    localparam int CW = CLOG2(WIDTH + 1);

    state_t           st, st_n;
    logic [WIDTH-1:0] sr, sr_n, sr_sh;
    logic [CW-1:0]    cnt, cnt_n;
    logic             x_n, ready_n, busy_n;
    logic             last;
    logic             presc_clr, presc_en;
`ifdef SERIALIZER_PARITY_EN
    logic             par, par_n;
`endif

    assign sr_sh = (MSB_FIRST != 0) ? (sr << 1) : (sr >> 1);
    assign last  = (cnt == CW'(WIDTH - 1));

    always_comb begin
        st_n    = st;
        sr_n    = sr;
        cnt_n   = cnt;
        x_n     = x;
        ready_n = ready;
        busy_n  = busy;
`ifdef SERIALIZER_PARITY_EN
        par_n   = par;
`endif
        case (st)
            IDLE: begin
                if (load) begin
                    st_n    = SHIFT;
                    sr_n    = din;
                    cnt_n   = '0;
                    x_n     = (MSB_FIRST != 0) ? din[WIDTH-1] : din[0];
                    ready_n = 1'b0;
                    busy_n  = 1'b1;
`ifdef SERIALIZER_PARITY_EN
                    par_n   = ^din;
`endif
                end
            end
            SHIFT: begin
                if (step) begin
                    if (last) begin
`ifdef SERIALIZER_PARITY_EN
                        st_n    = PAR;
                        x_n     = par;
`else
                        st_n    = IDLE;
                        x_n     = 1'b1;
                        ready_n = 1'b1;
                        busy_n  = 1'b0;
`endif
                    end else begin
                        cnt_n = cnt + CW'(1);
                        sr_n  = sr_sh;
                        x_n   = (MSB_FIRST != 0) ? sr_sh[WIDTH-1] : sr_sh[0];
                    end
                end
            end
`ifdef SERIALIZER_PARITY_EN
            PAR: begin
                if (step) begin
                    st_n    = IDLE;
                    x_n     = 1'b1;
                    ready_n = 1'b1;
                    busy_n  = 1'b0;
                end
            end
`endif
            default: begin
                st_n    = IDLE;
                x_n     = 1'b1;
                ready_n = 1'b1;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st    <= IDLE;
            sr    <= '0;
            cnt   <= '0;
            x     <= 1'b1;
            ready <= 1'b1;
            busy  <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            st    <= st_n;
            sr    <= sr_n;
            cnt   <= cnt_n;
            x     <= x_n;
            ready <= ready_n;
            busy  <= busy_n;
`ifdef SERIALIZER_PARITY_EN
            par   <= par_n;
`endif
        end
    end

    // Prescaler restarts on an accepted load and stops on the final step
    assign presc_clr = (st == IDLE) && load;
    assign presc_en  = (st != IDLE) && (st_n != IDLE);

    tick_prescaler #(.DIV(DIV)) u_presc (
        .clk  (clk),
        .rst  (rst),
        .clr  (presc_clr),
        .en   (presc_en),
        .tick (step)
    );

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench: MSB-first and LSB-first at DIV=4, DIV=1 with load held high,
// ignored loads while busy, and asynchronous reset mid-word.
module tb_bit_serializer;

`ifdef SERIALIZER_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load0 = 1'b0, load1 = 1'b0, load2 = 1'b0;
    logic [7:0] din0 = '0, din1 = '0, din2 = '0;
    logic       rdy0, x0, st0, bz0;
    logic       rdy1, x1, st1, bz1;
    logic       rdy2, x2, st2, bz2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(8), .DIV(4), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst(rst), .load(load0), .din(din0),
        .ready(rdy0), .x(x0), .step(st0), .busy(bz0));

    bit_serializer #(.WIDTH(8), .DIV(4), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst(rst), .load(load1), .din(din1),
        .ready(rdy1), .x(x1), .step(st1), .busy(bz1));

    bit_serializer #(.WIDTH(8), .DIV(1), .MSB_FIRST(1)) u_fast (
        .clk(clk), .rst(rst), .load(load2), .din(din2),
        .ready(rdy2), .x(x2), .step(st2), .busy(bz2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // idx counts bits on the wire; idx 8 is the parity bit when enabled
    function automatic logic ebit(input logic [7:0] w, input bit msb, input int idx);
        if (idx >= 8) return ^w;
        return msb ? w[7 - idx] : w[idx];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_word(input logic [7:0] a, input logic [7:0] b, input bit inject);
        load0 = 1'b1; din0 = a;
        load1 = 1'b1; din1 = b;
        tick();
        load0 = 1'b0; load1 = 1'b0;
        for (int k = 1; k <= NB * 4; k++) begin
            int idx;
            idx = (k - 1) / 4;
            chk($sformatf("msb_x@%0d", k), x0, ebit(a, 1'b1, idx));
            chk($sformatf("msb_step@%0d", k), st0, (k % 4 == 0));
            chk($sformatf("msb_busy@%0d", k), bz0, 1);
            chk($sformatf("msb_ready@%0d", k), rdy0, 0);
            chk($sformatf("lsb_x@%0d", k), x1, ebit(b, 1'b0, idx));
            chk($sformatf("lsb_step@%0d", k), st1, (k % 4 == 0));
            if (inject && k == 9) begin
                load0 = 1'b1; din0 = 8'hFF;
            end else begin
                load0 = 1'b0;
            end
            tick();
        end
        chk("msb_ready_end", rdy0, 1);
        chk("msb_busy_end", bz0, 0);
        chk("msb_x_end", x0, 1);
        chk("msb_step_end", st0, 0);
        chk("lsb_ready_end", rdy1, 1);
        chk("lsb_x_end", x1, 1);
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_ready", rdy0, 1);
        chk("rst_busy", bz0, 0);
        chk("rst_x", x0, 1);
        chk("rst_step", st0, 0);
        chk("rst_fast_x", x2, 1);
        rst = 1'b0;
        tick();
        chk("idle_ready", rdy1, 1);
        chk("idle_x", x1, 1);
        chk("idle_fast_ready", rdy2, 1);

        // A5 MSB-first with an ignored FF load mid-word; 01 LSB-first alongside
        run_word(8'hA5, 8'h01, 1'b1);
        tick();
        run_word(8'h07, 8'h80, 1'b0);
        tick();

        // DIV=1, load held high: back-to-back words with one idle cycle
        load2 = 1'b1; din2 = 8'hC3;
        tick();
        for (int k = 1; k <= 3 * (NB + 1); k++) begin
            int p;
            p = (k - 1) % (NB + 1);
            if (p < NB) begin
                chk($sformatf("fast_x@%0d", k), x2, ebit(8'hC3, 1'b1, p));
                chk($sformatf("fast_step@%0d", k), st2, 1);
                chk($sformatf("fast_busy@%0d", k), bz2, 1);
            end else begin
                chk($sformatf("fast_idle_x@%0d", k), x2, 1);
                chk($sformatf("fast_idle_step@%0d", k), st2, 0);
                chk($sformatf("fast_idle_ready@%0d", k), rdy2, 1);
            end
            tick();
        end
        load2 = 1'b0;

        // Reset mid-word: outputs return to idle at once, no further steps
        load0 = 1'b1; din0 = 8'hA5;
        tick();
        load0 = 1'b0;
        repeat (5) tick();
        chk("pre_rst_busy", bz0, 1);
        rst = 1'b1;
        #1;
        chk("async_ready", rdy0, 1);
        chk("async_busy", bz0, 0);
        chk("async_x", x0, 1);
        chk("async_step", st0, 0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            chk($sformatf("post_rst_step@%0d", k), st0, 0);
            chk($sformatf("post_rst_busy@%0d", k), bz0, 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
